// File: rtl/data_sram_resp_pkg.sv
// Shared constants, queue entry type and LFSR step for data_sram_resp.
// The LFSR is only used when DATA_SRAM_RESP_RANDOM_STALL_EN is defined.
package data_sram_resp_pkg;

  localparam int DATA_SRAM_RESP_ADDR_BITS = 12;
  localparam int DATA_SRAM_RESP_DEPTH     = 4;
  localparam int DATA_SRAM_RESP_LATENCY   = 2;

  localparam int RESP_ENTRY_W = 33;

  localparam logic [15:0] RESP_LFSR_SEED = 16'hACE1;
  // Galois form of x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] RESP_LFSR_TAPS = 16'hB400;

  typedef struct packed {
    logic        wr;
    logic [31:0] rdata;
  } resp_entry_t;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ RESP_LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/data_sram_resp_fifo.sv
// In-order completion queue for data_sram_resp: entry storage plus wrap-bit pointers.
// Only the pointers are reset; storage contents are don't-care while empty.
module resp_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]      wptr;
  logic [PW:0]      rptr;
  logic [WIDTH-1:0] store [DEPTH];

  assign empty = (wptr == rptr);
  assign full  = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
  assign head  = store[rptr[PW-1:0]];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + 1'b1;
      if (pop && !empty) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) store[wptr[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/data_sram_resp.sv
// Data-side SRAM-like responder: accept-time RAM access, in-order completions after LATENCY.
// Define DATA_SRAM_RESP_RANDOM_STALL_EN for LFSR-driven accept stalls and extra latency.
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int ADDR_BITS = DATA_SRAM_RESP_ADDR_BITS,
  parameter int DEPTH     = DATA_SRAM_RESP_DEPTH,
  parameter int LATENCY   = DATA_SRAM_RESP_LATENCY
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_req,
  input  logic        data_cache,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [2:0]  data_size,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic [31:0] data_rdata,
  output logic        data_data_ok
);

  // Wide enough for LATENCY-1 plus up to 7 extra stall cycles.
  localparam int              CNT_W       = $clog2(LATENCY + 8);
  localparam logic [CNT_W-1:0] BASE_RELOAD = CNT_W'(LATENCY - 1);

  logic [31:0]          mem [0:(1<<ADDR_BITS)-1];
  logic [ADDR_BITS-1:0] idx;
  logic                 hs;
  logic                 stall;
  logic [CNT_W-1:0]     reload;
  logic [CNT_W-1:0]     countdown;
  logic                 head_ready;
  logic                 fifo_full;
  logic                 fifo_empty;
  resp_entry_t          push_e;
  resp_entry_t          head_e;
  logic                 unused_inputs;

  assign idx = data_addr[ADDR_BITS+1:2];

`ifdef DATA_SRAM_RESP_RANDOM_STALL_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) lfsr <= RESP_LFSR_SEED;
    else         lfsr <= lfsr_step(lfsr);
  end

  assign stall  = lfsr[0];
  assign reload = BASE_RELOAD + CNT_W'(lfsr[3:1]);
`else
  assign stall  = 1'b0;
  assign reload = BASE_RELOAD;
`endif

  assign data_addr_ok = resetn && !fifo_full && !stall;
  assign hs           = data_req && data_addr_ok;

  assign head_ready   = !fifo_empty && (countdown == '0);
  assign data_data_ok = head_ready;
  assign data_rdata   = (head_ready && !head_e.wr) ? head_e.rdata : 32'h0;

  // Reads sample the RAM at accept time, so a read right after a write sees it.
  assign push_e = '{wr: data_wr, rdata: (data_wr ? 32'h0 : mem[idx])};

  resp_fifo #(
    .WIDTH (RESP_ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (hs),
    .push_data (push_e),
    .pop       (head_ready),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head_e)
  );

  // Reload whenever a new entry becomes head; a reload onto an empty queue is harmless.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      countdown <= '0;
    end else if ((hs && fifo_empty) || head_ready) begin
      countdown <= reload;
    end else if (countdown != '0) begin
      countdown <= countdown - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (hs && data_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (data_wstrb[b]) mem[idx][8*b +: 8] <= data_wdata[8*b +: 8];
      end
    end
  end

  assign unused_inputs = ^{data_cache, data_size, data_addr[31:ADDR_BITS+2], data_addr[1:0]};

endmodule

// File: tb/tb_data_sram_resp.sv
// Bench for data_sram_resp: three instances (LATENCY 2, 8, 1) against a completion-time model.
module tb_data_sram_resp;

  localparam int AB    = 12;
  localparam int DEPTH = 4;
  localparam int NDUT  = 3;

  function automatic int lat_of(input int d);
    case (d)
      0:       return 2;
      1:       return 8;
      default: return 1;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        resetn;
  logic        cache;
  logic        req   [NDUT];
  logic        wr    [NDUT];
  logic [3:0]  wstrb [NDUT];
  logic [31:0] addr  [NDUT];
  logic [31:0] wdata [NDUT];
  logic        aok   [NDUT];
  logic        dok   [NDUT];
  logic [31:0] rdata [NDUT];

  always #5 clk = ~clk;

  data_sram_resp #(.ADDR_BITS(AB), .DEPTH(DEPTH), .LATENCY(2)) u_l2 (
    .clk(clk), .resetn(resetn), .data_req(req[0]), .data_cache(cache), .data_wr(wr[0]),
    .data_wstrb(wstrb[0]), .data_addr(addr[0]), .data_size(3'd2), .data_wdata(wdata[0]),
    .data_addr_ok(aok[0]), .data_rdata(rdata[0]), .data_data_ok(dok[0]));

  data_sram_resp #(.ADDR_BITS(AB), .DEPTH(DEPTH), .LATENCY(8)) u_l8 (
    .clk(clk), .resetn(resetn), .data_req(req[1]), .data_cache(cache), .data_wr(wr[1]),
    .data_wstrb(wstrb[1]), .data_addr(addr[1]), .data_size(3'd2), .data_wdata(wdata[1]),
    .data_addr_ok(aok[1]), .data_rdata(rdata[1]), .data_data_ok(dok[1]));

  data_sram_resp #(.ADDR_BITS(AB), .DEPTH(DEPTH), .LATENCY(1)) u_l1 (
    .clk(clk), .resetn(resetn), .data_req(req[2]), .data_cache(cache), .data_wr(wr[2]),
    .data_wstrb(wstrb[2]), .data_addr(addr[2]), .data_size(3'd2), .data_wdata(wdata[2]),
    .data_addr_ok(aok[2]), .data_rdata(rdata[2]), .data_data_ok(dok[2]));

  // Reference model: each accepted request completes at max(accept, previous completion) + LATENCY.
  int          mcnt [NDUT];
  int          qh [NDUT];
  int          qt [NDUT];
  int          last_comp [NDUT];
  int          qcomp [NDUT][8];
  logic        qwr [NDUT][8];
  logic [31:0] qdat [NDUT][8];
  logic [31:0] mram [NDUT][4096];
  logic        hs [NDUT];

  int          cyc = 0;
  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          log_dut = -1;
  int          log_cyc[$];
  logic [31:0] log_dat[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    int          h;
    int          idx;
    int          c;
    logic        eaok;
    logic        edok;
    logic [31:0] erd;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      if (!resetn) begin
        mcnt[d] = 0; qh[d] = 0; qt[d] = 0; last_comp[d] = -1000;
      end
      h    = qh[d];
      eaok = resetn && (mcnt[d] < DEPTH);
      edok = resetn && (mcnt[d] > 0) && (qcomp[d][h] == cyc);
      erd  = (edok && !qwr[d][h]) ? qdat[d][h] : 32'h0;
      chk($sformatf("u%0d addr_ok", d), 32'(aok[d]), 32'(eaok));
      chk($sformatf("u%0d data_ok", d), 32'(dok[d]), 32'(edok));
      chk($sformatf("u%0d rdata", d), rdata[d], erd);
      if (d == log_dut && dok[d] === 1'b1) begin
        log_cyc.push_back(cyc);
        log_dat.push_back(rdata[d]);
      end
      hs[d] = eaok && req[d];
      if (edok) begin
        qh[d] = (h + 1) % 8;
        mcnt[d]--;
      end
      if (hs[d]) begin
        idx = int'(addr[d][AB+1:2]);
        c   = ((cyc > last_comp[d]) ? cyc : last_comp[d]) + lat_of(d);
        qcomp[d][qt[d]] = c;
        qwr[d][qt[d]]   = wr[d];
        qdat[d][qt[d]]  = wr[d] ? 32'h0 : mram[d][idx];
        if (wr[d]) begin
          for (int b = 0; b < 4; b++)
            if (wstrb[d][b]) mram[d][idx][8*b +: 8] = wdata[d][8*b +: 8];
        end
        qt[d] = (qt[d] + 1) % 8;
        mcnt[d]++;
        last_comp[d] = c;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // Holds the request until the model sees it accepted; req stays high on return.
  task automatic issue(input int d, input logic w, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] wd);
    bit done = 0;
    req[d] = 1'b1; wr[d] = w; addr[d] = a; wstrb[d] = s; wdata[d] = wd;
    for (int n = 0; n < 64 && !done; n++) begin
      tick();
      done = hs[d];
    end
    if (!done) begin
      total_cnt++;
      $error("FAIL u%0d accept timeout: observed no accept expected accept", d);
    end
  endtask

  task automatic drain();
    int n = 0;
    for (int d = 0; d < NDUT; d++) req[d] = 1'b0;
    while ((mcnt[0] + mcnt[1] + mcnt[2]) != 0 && n < 200) begin
      tick();
      n++;
    end
    if (n == 200) begin
      total_cnt++;
      $error("FAIL drain timeout: observed %0d pending expected 0", mcnt[0] + mcnt[1] + mcnt[2]);
    end
  endtask

  task automatic rand_req(input int d);
    logic [31:0] a;
    a        = $urandom;
    a[13:6]  = 8'h0;
    a[5:2]   = 4'($urandom_range(0, 15));
    req[d]   = ($urandom_range(0, 3) != 0);
    wr[d]    = 1'($urandom_range(0, 1));
    addr[d]  = a;
    wstrb[d] = 4'($urandom_range(0, 15));
    wdata[d] = $urandom;
  endtask

  task automatic start_log(input int d);
    log_dut = d;
    log_cyc.delete();
    log_dat.delete();
  endtask

  function automatic logic [31:0] alias_addr(input int k);
    logic [31:0] a;
    a       = $urandom;
    a[13:2] = 12'(k);
    return a;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          t;
    int          start;
    int          acc [6];
    logic [31:0] wd [8];
    logic [31:0] v;

    resetn = 1'b0;
    cache  = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      req[d] = 1'b0; wr[d] = 1'b0; wstrb[d] = 4'h0; addr[d] = 32'h0; wdata[d] = 32'h0;
    end
    tick();
    tick();
    resetn = 1'b1;
    tick();

    // Known contents for words 0..15 of every instance.
    for (int d = 0; d < NDUT; d++) begin
      for (int k = 0; k < 16; k++) issue(d, 1'b1, alias_addr(k), 4'hF, $urandom);
      req[d] = 1'b0;
    end
    drain();

    // Write then read at LATENCY 2.
    start_log(0);
    issue(0, 1'b1, 32'h100, 4'hF, 32'hDEADBEEF);
    t = cyc - 1;
    issue(0, 1'b0, 32'h100, 4'hF, 32'h0);
    drain();
    chk("wr_rd count", 32'(log_cyc.size()), 32'd2);
    if (log_cyc.size() >= 2) begin
      chk("wr_rd first cycle", 32'(log_cyc[0]), 32'(t + 2));
      chk("wr_rd second cycle", 32'(log_cyc[1]), 32'(t + 4));
      chk("wr_rd write rdata", log_dat[0], 32'h0);
      chk("wr_rd read rdata", log_dat[1], 32'hDEADBEEF);
    end

    // Byte strobes.
    start_log(0);
    issue(0, 1'b1, 32'h40, 4'hF, 32'h11223344);
    issue(0, 1'b1, 32'h40, 4'b0101, 32'hAABBCCDD);
    issue(0, 1'b0, 32'h40, 4'h0, 32'h0);
    drain();
    chk("strobe count", 32'(log_dat.size()), 32'd3);
    if (log_dat.size() == 3) chk("strobe rdata", log_dat[2], 32'h11BB33DD);

    // Aliasing of upper address bits.
    start_log(0);
    issue(0, 1'b1, 32'h0000_0010, 4'hF, 32'h5);
    issue(0, 1'b0, 32'h8000_4010, 4'hF, 32'h0);
    drain();
    chk("alias count", 32'(log_dat.size()), 32'd2);
    if (log_dat.size() == 2) chk("alias rdata", log_dat[1], 32'h5);

    // Full queue at LATENCY 8.
    start_log(1);
    for (int k = 0; k < 6; k++) begin
      issue(1, 1'b0, alias_addr(k), 4'h0, 32'h0);
      acc[k] = cyc - 1;
    end
    drain();
    chk("full count", 32'(log_cyc.size()), 32'd6);
    chk("full 4th accept", 32'(acc[3]), 32'(acc[0] + 3));
    chk("full 5th accept", 32'(acc[4]), 32'(acc[0] + 9));
    if (log_cyc.size() == 6) begin
      chk("full 5th after first ok", 32'(acc[4]), 32'(log_cyc[0] + 1));
      chk("full last ok cycle", 32'(log_cyc[5]), 32'(acc[0] + 48));
      for (int k = 0; k < 6; k++) chk($sformatf("full order %0d", k), log_dat[k], mram[1][k]);
    end

    // Reset with three reads outstanding.
    start_log(1);
    for (int k = 7; k < 10; k++) issue(1, 1'b0, alias_addr(k), 4'h0, 32'h0);
    req[1] = 1'b0;
    tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    #1;
    chk("addr_ok after reset", 32'(aok[1]), 32'd1);
    for (int n = 0; n < 20; n++) tick();
    chk("no ok after reset", 32'(log_cyc.size()), 32'd0);
    issue(1, 1'b0, alias_addr(3), 4'h0, 32'h0);
    drain();
    chk("ram kept count", 32'(log_dat.size()), 32'd1);
    if (log_dat.size() == 1) chk("ram kept rdata", log_dat[0], mram[1][3]);

    // LATENCY 1 streaming of alternating writes and reads.
    start_log(2);
    start = cyc;
    for (int k = 0; k < 8; k++) begin
      wd[k] = $urandom;
      issue(2, 1'b1, alias_addr(k + 20), 4'hF, wd[k]);
      issue(2, 1'b0, alias_addr(k + 20), 4'h0, 32'h0);
    end
    chk("stream accept cycles", 32'(cyc - start), 32'd16);
    drain();
    chk("stream count", 32'(log_cyc.size()), 32'd16);
    if (log_cyc.size() == 16) begin
      for (int i = 1; i < 16; i++) chk($sformatf("stream ok %0d", i), 32'(log_cyc[i]), 32'(log_cyc[0] + i));
      for (int k = 0; k < 8; k++) chk($sformatf("stream rdata %0d", k), log_dat[2*k+1], wd[k]);
    end

    // Write with no strobes leaves the word alone.
    start_log(2);
    v = mram[2][2];
    issue(2, 1'b1, alias_addr(2), 4'h0, ~v);
    issue(2, 1'b0, alias_addr(2), 4'h0, 32'h0);
    drain();
    chk("wstrb0 count", 32'(log_dat.size()), 32'd2);
    if (log_dat.size() == 2) chk("wstrb0 rdata", log_dat[1], v);

    // Random traffic on all three instances.
    start_log(-1);
    for (int d = 0; d < NDUT; d++) rand_req(d);
    for (int n = 0; n < 400; n++) begin
      cache = 1'($urandom_range(0, 1));
      tick();
      for (int d = 0; d < NDUT; d++)
        if (hs[d] || !req[d]) rand_req(d);
    end
    drain();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/data_sram_resp.md
# data_sram_resp

Responder for the core's data-side SRAM-like request channel (req / addr_ok / data_ok). It accepts one request per cycle into an in-order outstanding queue and performs the access on a local word-addressed RAM. It returns completions in order after a programmable latency. It serves as the data-memory model behind the core in simulation and as a tightly coupled scratchpad in small FPGA builds.

## Interface
Parameters:
- ADDR_BITS, 12: word-index width; RAM holds 2^ADDR_BITS 32-bit words.
- DEPTH, 4: outstanding-queue entries; power of two, at least 2.
- LATENCY, 2: cycles from an entry becoming queue head to its data_ok; at least 1.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  reset, asynchronous assertion, active-low.
- data_req  in  1  request valid.
- data_cache  in  1  cacheability attribute; accepted and ignored.
- data_wr  in  1  1 = write, 0 = read.
- data_wstrb  in  4  byte enables for writes.
- data_addr  in  32  byte address; bits [ADDR_BITS+1:2] index the RAM, all other bits ignored (aliasing).
- data_size  in  3  access size; informational only, data_wstrb is authoritative.
- data_wdata  in  32  write data.
- data_addr_ok  out  1  request accepted this cycle when data_req is also high.
- data_rdata  out  32  read data, valid only while data_ok is high.
- data_data_ok  out  1  one-cycle completion pulse, one per accepted request, for both reads and writes.

## Operation
- Accept: data_addr_ok = resetn && !full (plus any stall from the Configuration feature). A handshake occurs when data_req && data_addr_ok at a rising edge.
- The RAM access happens at accept time.
  - Write: each byte i with wstrb[i] set is updated.
  - Read: the word is captured into the pushed entry.
- Accept-time access guarantees read-after-write ordering between consecutive requests.
- Queue entry fields: {wr, rdata[31:0]}. Push happens on handshake, pop happens on data_ok.
- Head countdown:
  - Loaded with LATENCY-1 when an entry becomes head, either on push into an empty queue or on pop with more entries remaining.
  - Decrements each cycle. data_ok is asserted while the queue is non-empty and the countdown is 0.
- data_rdata = head.rdata when data_ok is high and head.wr is 0; otherwise 32'h0.
- Full: no push, even in a cycle with a simultaneous pop. There is no pass-through.
- Empty: data_ok is 0. Push into an empty queue and pop of the same entry never occur in the same cycle.
- Pointers are log2(DEPTH)+1 bits and wrap modulo 2·DEPTH. full/empty are decided by the MSB and equality compare.
- Write with wstrb = 0: completes normally and leaves the RAM unchanged.
- Reset, including mid-operation:
  - Queue is emptied, pointers are cleared, countdown is cleared, and outstanding completions are dropped.
  - RAM contents are retained and are not cleared by reset. Power-up contents are undefined.
- Outputs during reset: data_addr_ok = 0, data_data_ok = 0, data_rdata = 0.

## Timing
- Handshake at edge T gives head at cycle T+1 (if the queue was empty) and data_ok in cycle T+LATENCY.
- LATENCY = 1 gives sustained throughput of 1 request/cycle. In general, throughput is 1 completion per LATENCY cycles.
- data_addr_ok depends combinationally on registered state and resetn only, never on data_req.
- data_data_ok and data_rdata are driven from registers and the queue read port, with no combinational path from inputs.
- First cycle after resetn deasserts: data_addr_ok = 1.

## Configuration
- DATA_SRAM_RESP_RANDOM_STALL_EN defined:
  - A 16-bit LFSR (seed 16'hACE1, reset by resetn) runs every cycle.
  - LFSR bit 0 = 1 forces data_addr_ok to 0 for that cycle.
  - LFSR bits [3:1] are added to the countdown reload value, giving 0–7 extra cycles of latency per completion.
  - Ordering and data results are unchanged.
- Not defined: LFSR is absent, and timing is exactly as specified in Timing.

## Structure
- The following go in common.vh:
  - Default values for DATA_SRAM_RESP_ADDR_BITS, DEPTH and LATENCY.
  - Entry width constant (33).
  - LFSR seed and taps.
- Sub-module resp_fifo holds the entry storage and pointer logic. Parameters: WIDTH, DEPTH. Signals: push/pop/full/empty/head. It has an async active-low reset on pointers only.
- RAM, countdown and LFSR sit in the top level.

## Test plan
- Write then read: write 32'hDEADBEEF to 0x100 with wstrb 4'hF, then read 0x100 with LATENCY 2. Required: two data_ok pulses, in cycles T+2 and T+4. The second carries rdata 32'hDEADBEEF.
- Byte strobes: RAM at 0x40 holds 32'h11223344; write 32'hAABBCCDD with wstrb 4'b0101. A read must return 32'h11BB33DD.
- Full queue: DEPTH 4, LATENCY 8, data_req held high for 6 reads. addr_ok must drop after the 4th accept and rise the cycle after the first data_ok. Exactly 6 data_ok pulses, in order.
- Aliasing: write 32'h5 to 0x0000_0010, then read 0x8000_4010 with ADDR_BITS 12. Required: returns 32'h5.
- Reset mid-flight: 3 reads outstanding, pulse resetn low for one cycle. Required: no data_ok is ever produced for them, addr_ok = 1 the cycle after release, and prior RAM contents are still readable.
- LATENCY 1 streaming: 16 back-to-back alternating writes and reads. Required: addr_ok stays 1 throughout, data_ok is high 16 consecutive cycles, and all read data is correct.
